// File: rtl/prime_check_sched.sv
// Round-robin scheduler: several requesters share one prime-test engine.
// Each job runs IDLE->START->WAIT->RESP, and a watchdog aborts an engine that never answers.
module prime_check_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_num,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_prime,
  output logic            rsp_timeout,
  output logic            eng_start,
  output logic [W-1:0]    eng_number,
  input  logic            eng_done,
  input  logic            eng_is_prime,
  output logic            busy,
  output logic [IW-1:0]   grant_id,
  output logic [15:0]     jobs_done,
  output logic [15:0]     primes_found
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    num_q, num_d;
  logic [IW-1:0]   id_q, id_d;
  logic            prime_q, prime_d;
  logic            to_q, to_d;
  logic [15:0]     jobs_done_q, jobs_done_d;
  logic [15:0]     primes_found_q, primes_found_d;

  logic            found;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] rdy;
  int              idx;

  // First valid requester at or above rr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    num_d          = num_q;
    id_d           = id_q;
    prime_d        = prime_q;
    to_d           = to_q;
    jobs_done_d    = jobs_done_q;
    primes_found_d = primes_found_q;
    rdy            = '0;
    rsp_valid      = '0;
    rsp_prime      = 1'b0;
    rsp_timeout    = 1'b0;
    eng_start      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          rdy[win] = 1'b1;
          num_d    = req_num[int'(win)*W +: W];
          id_d     = win;
          state_d  = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          prime_d = eng_is_prime;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          prime_d = 1'b0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        rsp_prime       = prime_q;
        rsp_timeout     = to_q;
        rr_d            = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
        if (!(&jobs_done_q)) jobs_done_d = jobs_done_q + 16'd1;
        if (prime_q && !(&primes_found_q)) primes_found_d = primes_found_q + 16'd1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      cnt_q          <= '0;
      num_q          <= '0;
      id_q           <= '0;
      prime_q        <= 1'b0;
      to_q           <= 1'b0;
      jobs_done_q    <= '0;
      primes_found_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      cnt_q          <= cnt_d;
      num_q          <= num_d;
      id_q           <= id_d;
      prime_q        <= prime_d;
      to_q           <= to_d;
      jobs_done_q    <= jobs_done_d;
      primes_found_q <= primes_found_d;
    end
  end

  // The grant is combinational on req_valid, so hold it low while reset is applied.
  assign req_ready    = rst_n ? rdy : '0;
  assign busy         = (state_q != IDLE);
  assign eng_number   = num_q;
  assign grant_id     = id_q;
  assign jobs_done    = jobs_done_q;
  assign primes_found = primes_found_q;

endmodule

// File: tb/tb_prime_check_sched.sv
// Directed and randomized jobs against a behavioural engine and a reference scheduler model.
module tb_prime_check_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TMO  = 255;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_num = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic            rsp_prime, rsp_timeout, eng_start, busy;
  logic [W-1:0]    eng_number;
  logic            eng_done = 1'b0, eng_is_prime = 1'b0;
  logic [1:0]      grant_id;
  logic [15:0]     jobs_done, primes_found;

  int n_cmp = 0, n_bad = 0;
  int mptr = 0, mjobs = 0, mprimes = 0;
  int eng_lat = 0;
  bit eng_hang = 0;
  bit ebusy = 0, eres = 0;
  int ecnt = 0;

  prime_check_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_num(req_num),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_prime(rsp_prime),
    .rsp_timeout(rsp_timeout), .eng_start(eng_start), .eng_number(eng_number),
    .eng_done(eng_done), .eng_is_prime(eng_is_prime), .busy(busy),
    .grant_id(grant_id), .jobs_done(jobs_done), .primes_found(primes_found)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime_ref(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
    return 1;
  endfunction

  // Engine: answers eng_lat cycles into WAIT, or never when eng_hang is set.
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_done = 1'b0;
      ebusy    = 1'b0;
    end else if (eng_start) begin
      eng_done = 1'b0;
      ebusy    = !eng_hang;
      ecnt     = eng_lat;
      eres     = is_prime_ref(int'(eng_number));
    end else if (ebusy) begin
      if (ecnt == 0) begin
        eng_done     = 1'b1;
        eng_is_prime = eres;
        ebusy        = 1'b0;
      end else ecnt--;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {req_ready, rsp_valid, rsp_prime, rsp_timeout, eng_start, eng_number,
                busy, grant_id, jobs_done, primes_found}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    mptr = 0; mjobs = 0; mprimes = 0;
  endtask

  function automatic int exp_winner();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  // Called while the DUT is idle with at least one request pending.
  task automatic serve_one(input int lat, input bit hang);
    int ew, num, k;
    bit ep, et;
    #1;
    ew  = exp_winner();
    num = int'(req_num[ew*W +: W]);
    eng_lat = lat; eng_hang = hang;
    check("idle_busy", busy, 0);
    check("grant_onehot", req_ready, 64'(1) << ew);
    tick();
    check("eng_start", eng_start, 1);
    check("eng_number", eng_number, num);
    check("grant_id", grant_id, ew);
    req_valid[ew] = 1'b0;
    tick();
    check("start_pulse_one_cycle", eng_start, 0);
    k = 0;
    while (rsp_valid == '0 && k < 400) begin
      tick();
      k++;
    end
    et = hang || lat > TMO;
    ep = !et && is_prime_ref(num);
    check("wait_cycles", k, et ? TMO + 1 : lat + 1);
    check("rsp_valid", rsp_valid, 64'(1) << ew);
    check("rsp_prime", rsp_prime, ep);
    check("rsp_timeout", rsp_timeout, et);
    if (mjobs < 16'hFFFF) mjobs++;
    if (ep && mprimes < 16'hFFFF) mprimes++;
    mptr = (ew + 1) % NREQ;
    tick();
    check("rsp_cleared", {rsp_valid, rsp_prime, rsp_timeout}, 0);
    check("jobs_done", jobs_done, mjobs);
    check("primes_found", primes_found, mprimes);
  endtask

  initial begin
    req_valid = 4'b1111;
    do_reset();

    // Single requester, prime 7.
    req_valid = 4'b0001;
    req_num   = {8'd0, 8'd0, 8'd0, 8'd7};
    serve_one(3, 0);

    // All four valid from reset: grants in index order.
    req_valid = 4'b1111;
    req_num   = {8'd1, 8'd13, 8'd9, 8'd2};
    do_reset();
    for (int j = 0; j < 4; j++) serve_one(j, 0);
    check("jobs_after_four", jobs_done, 4);
    check("primes_after_four", primes_found, 2);

    // Watchdog expiry, then engine answering on the very last WAIT cycle.
    req_valid = 4'b1000;
    req_num   = {8'd11, 8'd0, 8'd0, 8'd0};
    serve_one(0, 1);
    req_valid = 4'b0001;
    req_num   = {8'd0, 8'd0, 8'd0, 8'd13};
    serve_one(TMO, 0);

    // Reset during WAIT for requester 2.
    do_reset();
    eng_hang  = 1;
    req_valid = 4'b0100;
    req_num   = {8'd0, 8'd5, 8'd0, 8'd0};
    #1;
    check("mid_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    repeat (5) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_outputs");
    tick();
    check("mid_reset_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    mptr = 0; mjobs = 0; mprimes = 0;
    req_valid = 4'b0110;
    req_num   = {8'd0, 8'd17, 8'd4, 8'd0};
    serve_one(2, 0);
    serve_one(1, 0);

    // Randomized traffic with occasional withdrawn requests and watchdog hits.
    for (int r = 0; r < 12; r++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) req_num[i*W +: W] = 8'($urandom_range(0, 255));
      while (req_valid != '0) begin
        if ($countones(req_valid) > 1 && $urandom_range(0, 5) == 0) begin
          int d;
          d = $urandom_range(0, NREQ - 1);
          while (!req_valid[d]) d = (d + 1) % NREQ;
          req_valid[d] = 1'b0;
        end
        serve_one($urandom_range(0, 6), $urandom_range(0, 15) == 0);
      end
    end

    // Saturation of primes_found.
    force dut.primes_found_q = 16'hFFFF;
    tick();
    release dut.primes_found_q;
    mprimes = 16'hFFFF;
    check("primes_preload", primes_found, 16'hFFFF);
    req_valid = 4'b0010;
    req_num   = {8'd0, 8'd0, 8'd3, 8'd0};
    serve_one(1, 0);
    check("primes_saturated", primes_found, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prime_check_sched.md
PRIME_CHECK_SCHED -- requirements
Module: prime_check_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter W, default 8, giving the candidate number width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum engine cycles per job.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester job request.
REQ-007 The block SHALL have port req_num, input, NREQ*W bits: candidate for requester i, at bits [i*W +: W].
REQ-008 The block SHALL have port req_ready, output, NREQ bits: one-hot accept pulse.
REQ-009 The block SHALL have port rsp_valid, output, NREQ bits: one-hot result pulse to the owning requester.
REQ-010 The block SHALL have port rsp_prime, output, 1 bit: result, valid with rsp_valid.
REQ-011 The block SHALL have port rsp_timeout, output, 1 bit: job aborted by watchdog, valid with rsp_valid.
REQ-012 The block SHALL have port eng_start, output, 1 bit: one-cycle start pulse to the shared prime engine.
REQ-013 The block SHALL have port eng_number, output, W bits: candidate driven to the engine.
REQ-014 The block SHALL have port eng_done, input, 1 bit: engine level done, cleared by the engine at the edge that samples eng_start.
REQ-015 The block SHALL have port eng_is_prime, input, 1 bit: engine result, valid while eng_done=1.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port grant_id, output, clog2(NREQ) bits: index of the current or last job owner.
REQ-018 The block SHALL have ports jobs_done and primes_found, outputs, 16 bits each: saturating statistics counters.

Function
REQ-019 The FSM SHALL have four states, IDLE, START, WAIT and RESP, with transitions IDLE->START->WAIT->RESP->IDLE.
REQ-020 In IDLE with any req_valid set, the block SHALL select the winner round-robin, searching from rr_ptr upward with wrap.
REQ-021 In that same IDLE cycle, the block SHALL assert req_ready for the winner only, capture its req_num and id, and move to START.
REQ-022 A request SHALL be accepted only on a cycle where req_valid=1 and req_ready=1; requesters hold req_valid and req_num stable until then.
REQ-023 In START, the block SHALL assert eng_start=1 for exactly one cycle, with eng_number equal to the captured number.
REQ-024 eng_number SHALL hold the captured value from START through RESP, and SHALL hold the last value in IDLE.
REQ-025 In WAIT, the block SHALL sample eng_done; it never samples eng_done in START.
REQ-026 A WAIT counter SHALL be 0 in the first WAIT cycle and increment by 1 each WAIT cycle.
REQ-027 WAIT SHALL exit when eng_done=1, latching eng_is_prime and setting timeout=0.
REQ-028 WAIT SHALL also exit when the counter equals TIMEOUT, setting prime=0 and timeout=1.
REQ-029 If eng_done=1 and the counter equals TIMEOUT in the same cycle, eng_done SHALL win.
REQ-030 In RESP, the block SHALL pulse rsp_valid[id] for one cycle and drive rsp_prime and rsp_timeout.
REQ-031 In RESP, the block SHALL set rr_ptr=(id+1) mod NREQ and return to IDLE.
REQ-032 rsp_prime and rsp_timeout SHALL be 0 whenever rsp_valid is all-zero.
REQ-033 Minimum latency SHALL be: accept at T, eng_start at T+1, first WAIT at T+2, RESP at the cycle after eng_done is seen, next accept one cycle after RESP.
REQ-034 jobs_done SHALL increment in every RESP cycle, and primes_found SHALL increment in RESP when rsp_prime=1.
REQ-035 Both counters SHALL saturate at 16'hFFFF.
REQ-036 A requester deasserting req_valid before its grant SHALL lose the request with no side effect.
REQ-037 New req_valid assertions during START, WAIT or RESP SHALL be ignored until IDLE.

Reset
REQ-038 While rst_n=0, the block SHALL force state=IDLE, rr_ptr=0, the WAIT counter to 0, and the captured number and id to 0.
REQ-039 While rst_n=0, all outputs (req_ready, rsp_valid, rsp_prime, rsp_timeout, eng_start, eng_number, busy, grant_id, jobs_done, primes_found) SHALL be 0.
REQ-040 Reset mid-job SHALL abandon the job with no rsp_valid, and the first job after reset SHALL follow REQ-020 from rr_ptr=0.

Verification
REQ-041 Bench SHALL cover: req_valid=4'b0001, num 7, model engine -> req_ready[0] at T, eng_start at T+1, rsp_valid[0] with rsp_prime=1, jobs_done=1, primes_found=1.
REQ-042 Bench SHALL cover: all four requesters valid from reset with nums 2, 9, 13, 1 -> grants 0,1,2,3 in order, rsp_prime 1,0,1,0, then jobs_done=4, primes_found=2.
REQ-043 Bench SHALL cover: engine holding eng_done=0 with TIMEOUT=255 -> RESP exactly 256 WAIT cycles after entry, rsp_timeout=1, rsp_prime=0.
REQ-044 Bench SHALL cover: eng_done rising in the same cycle the counter reaches TIMEOUT, with eng_is_prime=1 -> rsp_timeout=0, rsp_prime=1.
REQ-045 Bench SHALL cover: rst_n low during WAIT for requester 2 -> no rsp_valid, outputs 0, next grant with requesters 1 and 2 both valid goes to 1.
REQ-046 Bench SHALL cover: primes_found preloaded via forced 16'hFFFF, then a prime result -> primes_found stays 16'hFFFF.
